// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states,
// access sizes, and the funct3 decode helpers used by the top level.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic      legal;
    lsu_size_e size;
    logic      uns;
  } lsu_dec_t;

  // Unsigned variants only exist for loads; any other code is illegal.
  function automatic lsu_dec_t lsu_decode(input logic [2:0] f3, input logic is_store);
    lsu_dec_t d;
    d.legal = 1'b0;
    d.size  = SZ_W;
    d.uns   = 1'b0;
    case (f3)
      F3_B:  begin d.legal = 1'b1;      d.size = SZ_B; end
      F3_H:  begin d.legal = 1'b1;      d.size = SZ_H; end
      F3_W:  begin d.legal = 1'b1;      d.size = SZ_W; end
      F3_BU: begin d.legal = !is_store; d.size = SZ_B; d.uns = 1'b1; end
      F3_HU: begin d.legal = !is_store; d.size = SZ_H; d.uns = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // Halfwords need bit 0 clear, words need both low bits clear.
  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_H:    mis = off[0];
      SZ_W:    mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port bundle: request side driven by the LSU, ready/rdata by memory.
interface load_store_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication,
// load lane extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  lsu_size_e   ld_size_i,
  input  logic        ld_uns_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;
  logic signed [31:0] ld_byte_sx;
  logic signed [31:0] ld_half_sx;

  // Store side: enables follow the lane offset, data is replicated across lanes.
  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      SZ_B: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      SZ_H: begin
        st_be_o    = 4'b0011 << st_off_i;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  // Load side: pick the addressed lane, then extend to the full word.
  always_comb begin
    ld_byte    = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
    ld_half    = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];
    ld_byte_sx = ld_byte;
    ld_half_sx = ld_half;
    case (ld_size_i)
      SZ_B:    ld_data_o = ld_uns_i ? {24'd0, ld_byte} : ld_byte_sx;
      SZ_H:    ld_data_o = ld_uns_i ? {16'd0, ld_half} : ld_half_sx;
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: decodes the access, runs one valid/ready transaction on the
// data-memory port with a timeout, and returns extended load data plus flags.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int SIGNAL_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mem_rw,
  input  logic [2:0]              funct3,
  input  logic [SIGNAL_WIDTH-1:0] alu_out,
  input  logic [SIGNAL_WIDTH-1:0] rs2_data,
  output logic [SIGNAL_WIDTH-1:0] load_data,
  output logic                    done,
  output logic                    stall,
  output logic                    misaligned,
  output logic                    fault,
  load_store_unit_if.master       dmem
);

  localparam int         W        = SIGNAL_WIDTH;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  lsu_size_e  size_q, size_d;
  logic       uns_q, uns_d;
  logic [1:0] off_q, off_d;
  logic [W-1:0] load_data_q, load_data_d;
  logic       mis_q, mis_d;
  logic       fault_q, fault_d;
  logic [W-1:0] addr_q, addr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic [3:0] be_q, be_d;

  lsu_dec_t   dec;
  logic       dec_mis;
  logic [3:0] st_be;
  logic [W-1:0] st_wdata;
  logic [W-1:0] ld_data;

  // Decode the incoming request; only consumed when IDLE sees start.
  always_comb begin
    dec     = lsu_decode(funct3, mem_rw);
    dec_mis = lsu_misaligned(dec.size, alu_out[1:0]);
  end

  lsu_align u_align (
    .st_size_i  (dec.size),
    .st_off_i   (alu_out[1:0]),
    .st_data_i  (rs2_data),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .ld_size_i  (size_q),
    .ld_uns_i   (uns_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (dmem.dmem_rdata),
    .ld_data_o  (ld_data)
  );

  // Next-state and registered-output logic for the access FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    mis_d       = mis_q;
    fault_d     = fault_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    be_d        = be_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mis_d   = 1'b0;
          fault_d = 1'b0;
          if (!dec.legal) begin
            fault_d = 1'b1;
            state_d = ST_DONE;
          end else if (dec_mis) begin
            mis_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d  = {alu_out[W-1:2], 2'b00};
            we_d    = mem_rw;
            be_d    = st_be;
            wdata_d = st_wdata;
            size_d  = dec.size;
            uns_d   = dec.uns;
            off_d   = alu_out[1:0];
            cnt_d   = 8'd0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (dmem.dmem_ready) begin
          if (!we_q) load_data_d = ld_data;
          state_d = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          fault_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears the whole unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      size_q      <= SZ_W;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      load_data_q <= '0;
      mis_q       <= 1'b0;
      fault_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
      mis_q       <= mis_d;
      fault_q     <= fault_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      be_q        <= be_d;
    end
  end

  // Outputs: request valid tracks REQ so an async reset drops it at once.
  always_comb begin
    dmem.dmem_req   = (state_q == ST_REQ);
    dmem.dmem_we    = we_q;
    dmem.dmem_addr  = addr_q;
    dmem.dmem_wdata = wdata_q;
    dmem.dmem_be    = be_q;
    done            = (state_q == ST_DONE);
    stall           = (state_q == ST_REQ) | ((state_q == ST_IDLE) & start);
    load_data       = load_data_q;
    misaligned      = mis_q;
    fault           = fault_q;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the ALU: takes the ALU result as the effective address and rs2 as store data.
- Runs a valid/ready transaction on the data-memory port, handling byte enables, lane alignment and load sign/zero extension.
- Stalls the core while an access is outstanding.
- Returns load data to the writeback mux, plus error flags for misaligned, illegal-funct3 and timed-out accesses.

Parameters:
- SIGNAL_WIDTH, 32, datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 16, maximum cycles in REQ waiting for dmem_ready before the access is aborted; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  control unit requests an access this cycle
- mem_rw  input  1  0 = load, 1 = store
- funct3  input  3  RISC-V width/sign code
- alu_out  input  32  effective address from ALU
- rs2_data  input  32  store source data
- load_data  output  32  extended load result
- done  output  1  one-cycle pulse when the access completes or errors
- stall  output  1  freezes PC/pipeline while asserted
- misaligned  output  1  address not aligned to access size (valid with done)
- fault  output  1  illegal funct3 or timeout (valid with done)
- dmem_req  output  1  memory request valid
- dmem_we  output  1  write enable
- dmem_addr  output  32  word address, i.e. {alu_out[31:2],2'b00}
- dmem_wdata  output  32  lane-shifted store data
- dmem_be  output  4  byte enables
- dmem_ready  input  1  memory accepts the request; read data valid this cycle
- dmem_rdata  input  32  read word

Behaviour:
- Reset is asynchronous and active-low (rst_n); all logic is clocked on the rising edge of clk.
- Reset values: state=IDLE; load_data=0; done=0; misaligned=0; fault=0; dmem_req=0; dmem_we=0; dmem_addr=0; dmem_wdata=0; dmem_be=0; timeout counter=0.
- States: IDLE, REQ, DONE.
- IDLE + start:
  - Decode funct3. Legal codes are 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only); a store with funct3 of 100 or 101 is illegal. Any other code sets fault=1 and goes to DONE with no memory access.
  - Misaligned means H with addr[0]=1, or W with addr[1:0]≠0. It sets misaligned=1 and goes to DONE with no memory access.
  - Otherwise latch address, size, sign and data, and go to REQ.
- REQ:
  - dmem_req=1. dmem_addr, dmem_we, dmem_be and dmem_wdata are registered and held stable until the ready cycle.
  - Counter increments each cycle.
  - dmem_ready=1: for a load, capture and extend dmem_rdata into load_data; go to DONE.
  - Counter reaches TIMEOUT_CYCLES without ready: drop dmem_req, set fault=1, go to DONE; load_data is unchanged.
- DONE: done=1 for exactly one cycle, then return to IDLE. Error flags are cleared on the next accepted start.
- Byte enables, with a=addr[1:0]:
  - B: 4'b0001<<a.
  - H: 4'b0011<<a.
  - W: 4'b1111.
  - Store data is replicated: B = {4{rs2[7:0]}}, H = {2{rs2[15:0]}}, W = rs2.
- Load extraction: select byte a or halfword a[1], then sign-extend (B, H) or zero-extend (BU, HU); W passes through.
- stall is combinational: stall = (state==REQ) | (state==IDLE & start). It is low in DONE so the core advances on the done cycle.
- Latency: best case start→done is 2 cycles (ready in first REQ cycle). Error paths take 1 cycle.
- start while not IDLE is ignored. The core guarantees this cannot happen because stall is high.
- load_data holds its last value until the next successful load.
- Reset mid-REQ: dmem_req deasserts immediately (asynchronous) and the transaction is abandoned. The memory model must tolerate a dropped request.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State encoding ST_IDLE/ST_REQ/ST_DONE.
  - Size encoding SZ_B/SZ_H/SZ_W.
- One combinational sub-module, lsu_align: store-side byte enables and lane replication, plus load-side extraction and extension. This keeps the FSM file free of datapath muxing.

Test Plan:
- LW, alu_out=0x100, ready on first REQ cycle, rdata=0xDEADBEEF → dmem_addr=0x100, dmem_be=4'b1111; done in cycle 2; load_data=0xDEADBEEF; stall high for 2 cycles.
- LB at 0x103, rdata=0x80FF_0000; then LBU at the same address → LB load_data=0xFFFFFF80; LBU load_data=0x00000080.
- SH, alu_out=0x202, rs2=0x1234ABCD, ready after 3 wait cycles → dmem_be=4'b1100, dmem_wdata=0xABCDABCD held for 4 cycles, dmem_we=1; done on the 5th cycle.
- Illegal accesses:
  - LW at 0x101 → misaligned=1, done after 1 cycle, dmem_req never asserted.
  - funct3=3'b011 → fault=1, same timing, no request.
- Load at 0x40 with dmem_ready held low, TIMEOUT_CYCLES=16 → dmem_req high for exactly 16 cycles then drops; fault=1 with done; load_data unchanged.
- rst_n asserted low during REQ → dmem_req=0, stall=0 and done=0 immediately; after release, a new LW completes normally.
